// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
package hazard_ctrl_pkg;

    // Tracked post-ID stages and register address width (fixed for this core)
    localparam int NSTAGE = 3;
    localparam int RW     = 5;

    // Scoreboard slot indices
    localparam int SB_ES = 0;
    localparam int SB_MS = 1;
    localparam int SB_WS = 2;

    // stallD encodings seen by id_stage
    localparam logic [1:0] STALL_NONE  = 2'b00;
    localparam logic [1:0] STALL_HOLD  = 2'b01;
    localparam logic [1:0] STALL_FLUSH = 2'b10;

    // Forward source select codes
    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_ES = 2'b01,
        FWD_MS = 2'b10,
        FWD_WS = 2'b11
    } fwd_sel_t;

    // One in-flight writer
    typedef struct packed {
        logic          v;
        logic [RW-1:0] dest;
        logic          we;
        logic          ld;
    } sb_entry_t;

    // True when entry e will write register addr that the ID instruction reads.
    // $0 never matches: it is hardwired and must always come from the regfile.
    function automatic logic sb_match(input sb_entry_t e, input logic [RW-1:0] addr,
                                      input logic used, input logic ds_valid);
        return e.v & e.we & (e.dest == addr) & (addr != '0) & used & ds_valid;
    endfunction

endpackage

// File: rtl/hz_match.sv
// Compares one ID operand against the ES/MS/WS scoreboard entries and picks
// the youngest matching writer.
module hz_match
    import hazard_ctrl_pkg::*;
(
    input  logic [RW-1:0] addr,
    input  logic          used,
    input  logic          ds_valid,
    input  sb_entry_t     sb_es,
    input  sb_entry_t     sb_ms,
    input  sb_entry_t     sb_ws,
    output logic          hit,
    output logic [1:0]    sel,
    output logic          ld_hit_es,
    output logic          ld_hit_ms
);

    logic m_es;
    logic m_ms;
    logic m_ws;

    assign m_es = sb_match(sb_es, addr, used, ds_valid);
    assign m_ms = sb_match(sb_ms, addr, used, ds_valid);
    assign m_ws = sb_match(sb_ws, addr, used, ds_valid);

    // Youngest writer wins: ES over MS over WS
    always_comb begin
        sel = FWD_RF;
        if (m_es)      sel = FWD_ES;
        else if (m_ms) sel = FWD_MS;
        else if (m_ws) sel = FWD_WS;
    end

    assign hit       = m_es | m_ms | m_ws;
    assign ld_hit_es = m_es & sb_es.ld;
    assign ld_hit_ms = m_ms & sb_ms.ld;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the ID stage of the 5-stage pipeline.
// Tracks ES/MS/WS writers in a shadow scoreboard and decides forward/stall.
// Optional HAZARD_PERF_EN adds stall/forward cycle counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            ds_valid,
    input  logic [2*RW-1:0] ds_to_es_addr,
    input  logic            ds_rs_used,
    input  logic            ds_rt_used,
    input  logic            ifbranch,
    input  logic [RW-1:0]   ds_dest,
    input  logic            ds_gr_we,
    input  logic            ds_is_load,
    input  logic            ds_to_es_fire,
    input  logic            es_to_ms_fire,
    input  logic            ms_to_ws_fire,
    input  logic            ws_retire,
    input  logic            ds_flush,
    output logic [1:0]      stallD,
    output logic [1:0]      ds_forward_ctrl,
    output logic [1:0]      fwd_rs_sel,
    output logic [1:0]      fwd_rt_sel
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_fwd_cnt
`endif
);

    sb_entry_t  sb [NSTAGE];
    logic       sb_load;
    logic       rs_hit, rt_hit;
    logic [1:0] rs_sel, rt_sel;
    logic       rs_ld_es, rt_ld_es, rs_ld_ms, rt_ld_ms;
    logic       hold;

    // A flushed ID instruction never enters the scoreboard
    assign sb_load = ds_to_es_fire & ~ds_flush;

    // Scoreboard shifts in register-transfer order; every stage updates at once
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NSTAGE; i++) sb[i] <= '0;
        end else begin
            if (sb_load)
                sb[SB_ES] <= '{v: 1'b1, dest: ds_dest, we: ds_gr_we, ld: ds_is_load};
            else if (es_to_ms_fire)
                sb[SB_ES].v <= 1'b0;

            if (es_to_ms_fire)
                sb[SB_MS] <= sb[SB_ES];
            else if (ms_to_ws_fire)
                sb[SB_MS].v <= 1'b0;

            if (ms_to_ws_fire)
                sb[SB_WS] <= sb[SB_MS];
            else if (ws_retire)
                sb[SB_WS].v <= 1'b0;
        end
    end

    hz_match u_match_rs (
        .addr      (ds_to_es_addr[2*RW-1:RW]),
        .used      (ds_rs_used),
        .ds_valid  (ds_valid),
        .sb_es     (sb[SB_ES]),
        .sb_ms     (sb[SB_MS]),
        .sb_ws     (sb[SB_WS]),
        .hit       (rs_hit),
        .sel       (rs_sel),
        .ld_hit_es (rs_ld_es),
        .ld_hit_ms (rs_ld_ms)
    );

    hz_match u_match_rt (
        .addr      (ds_to_es_addr[RW-1:0]),
        .used      (ds_rt_used),
        .ds_valid  (ds_valid),
        .sb_es     (sb[SB_ES]),
        .sb_ms     (sb[SB_MS]),
        .sb_ws     (sb[SB_WS]),
        .hit       (rt_hit),
        .sel       (rt_sel),
        .ld_hit_es (rt_ld_es),
        .ld_hit_ms (rt_ld_ms)
    );

    // Load-use, or a branch whose operand is still in ES (ALU result not wired
    // into the compare) or is a load sitting in MS
    assign hold = rs_ld_es | rt_ld_es
                | (ifbranch & ((rs_sel == FWD_ES) | (rt_sel == FWD_ES) | rs_ld_ms | rt_ld_ms));

    // Flush beats hold; any stall suppresses forwarding and zeroes the selects
    always_comb begin
        stallD          = STALL_NONE;
        fwd_rs_sel      = FWD_RF;
        fwd_rt_sel      = FWD_RF;
        ds_forward_ctrl = 2'b00;
        if (ds_flush) begin
            stallD = STALL_FLUSH;
        end else if (hold) begin
            stallD = STALL_HOLD;
        end else begin
            fwd_rs_sel      = rs_sel;
            fwd_rt_sel      = rt_sel;
            ds_forward_ctrl = {rs_hit, rt_hit};
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stallD == STALL_HOLD) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (|ds_forward_ctrl)     perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed vector bench for hazard_ctrl. Each vector drives one cycle of ID
// and handshake inputs and lists the outputs expected during that cycle.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       ds_valid;
    logic [9:0] ds_to_es_addr;
    logic       ds_rs_used, ds_rt_used, ifbranch;
    logic [4:0] ds_dest;
    logic       ds_gr_we, ds_is_load;
    logic       ds_to_es_fire, es_to_ms_fire, ms_to_ws_fire, ws_retire, ds_flush;
    logic [1:0] stallD, ds_forward_ctrl, fwd_rs_sel, fwd_rt_sel;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .ds_valid        (ds_valid),
        .ds_to_es_addr   (ds_to_es_addr),
        .ds_rs_used      (ds_rs_used),
        .ds_rt_used      (ds_rt_used),
        .ifbranch        (ifbranch),
        .ds_dest         (ds_dest),
        .ds_gr_we        (ds_gr_we),
        .ds_is_load      (ds_is_load),
        .ds_to_es_fire   (ds_to_es_fire),
        .es_to_ms_fire   (es_to_ms_fire),
        .ms_to_ws_fire   (ms_to_ws_fire),
        .ws_retire       (ws_retire),
        .ds_flush        (ds_flush),
        .stallD          (stallD),
        .ds_forward_ctrl (ds_forward_ctrl),
        .fwd_rs_sel      (fwd_rs_sel),
        .fwd_rt_sel      (fwd_rt_sel)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_fwd_cnt    (perf_fwd_cnt)
`endif
    );

    typedef struct {
        string      name;
        logic       rst, chk, val;
        logic [4:0] rs, rt;
        logic       rsu, rtu, br;
        logic [4:0] dest;
        logic       we, ld, df, ef, mf, wr, fl;
        logic [1:0] e_stall, e_fwd, e_rs, e_rt;
    } vec_t;

    function automatic vec_t mk(input string name, input int rst, input int chk, input int val,
                                input int rs, input int rt, input int rsu, input int rtu, input int br,
                                input int dest, input int we, input int ld,
                                input int df, input int ef, input int mf, input int wr, input int fl,
                                input int e_stall, input int e_fwd, input int e_rs, input int e_rt);
        vec_t v;
        v.name = name; v.rst = 1'(rst); v.chk = 1'(chk); v.val = 1'(val);
        v.rs = 5'(rs); v.rt = 5'(rt); v.rsu = 1'(rsu); v.rtu = 1'(rtu); v.br = 1'(br);
        v.dest = 5'(dest); v.we = 1'(we); v.ld = 1'(ld);
        v.df = 1'(df); v.ef = 1'(ef); v.mf = 1'(mf); v.wr = 1'(wr); v.fl = 1'(fl);
        v.e_stall = 2'(e_stall); v.e_fwd = 2'(e_fwd); v.e_rs = 2'(e_rs); v.e_rt = 2'(e_rt);
        return v;
    endfunction

    task automatic check(input string nm, input string what, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s %s: got %0h expected %0h", nm, what, act, exp);
        end
    endtask

    // Drive on the falling edge, compare just before the next rising edge
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        reset         = v.rst;
        ds_valid      = v.val;
        ds_to_es_addr = {v.rs, v.rt};
        ds_rs_used    = v.rsu;
        ds_rt_used    = v.rtu;
        ifbranch      = v.br;
        ds_dest       = v.dest;
        ds_gr_we      = v.we;
        ds_is_load    = v.ld;
        ds_to_es_fire = v.df;
        es_to_ms_fire = v.ef;
        ms_to_ws_fire = v.mf;
        ws_retire     = v.wr;
        ds_flush      = v.fl;
        #4;
        if (v.chk) begin
            check(v.name, "stallD", 32'(stallD), 32'(v.e_stall));
            check(v.name, "ds_forward_ctrl", 32'(ds_forward_ctrl), 32'(v.e_fwd));
            check(v.name, "fwd_rs_sel", 32'(fwd_rs_sel), 32'(v.e_rs));
            check(v.name, "fwd_rt_sel", 32'(fwd_rt_sel), 32'(v.e_rt));
        end
    endtask

    vec_t vecs[$];
`ifdef HAZARD_PERF_EN
    vec_t pvecs[$];
`endif

    initial begin
        //                  name              rst chk val rs rt rsu rtu br dest we ld df ef mf wr fl  stall fwd rs rt
        vecs.push_back(mk("reset",             1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_addu3",       0, 1, 1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("es_fwd_rs",         0, 1, 1, 3, 1, 1, 1, 0, 9, 1, 0, 1, 1, 0, 0, 0, 0, 2, 1, 0));
        vecs.push_back(mk("ms_fwd_rt",         0, 1, 1, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk("drain_a",           0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ws_fwd_retire",     0, 1, 1, 3, 9, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3, 3, 2));
        vecs.push_back(mk("after_retire",      0, 1, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("clear_ws",          0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_lw5",         0, 1, 1, 0, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("load_use_hold",     0, 1, 1, 2, 5, 1, 1, 0, 6, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("load_use_release",  0, 1, 1, 2, 5, 1, 1, 0, 6, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        vecs.push_back(mk("fill3",             0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("reset_mid",         1, 0, 1, 7, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("after_reset",       0, 1, 1, 7, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_addiu4",      0, 1, 1, 0, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("beq_hold_es",       0, 1, 1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("beq_release_ms",    0, 1, 1, 4, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2, 0));
        vecs.push_back(mk("drain_b",           0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_lw8",         0, 1, 0, 0, 0, 0, 0, 0, 8, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("lw8_to_ms",         0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("beq_hold_ms_ld",    0, 1, 1, 8, 4, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk("addu_ms_ws",        0, 1, 1, 8, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2, 3));
        vecs.push_back(mk("reset_b",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_7a",          0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_nowe1",       0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_7b",          0, 1, 0, 0, 0, 0, 0, 0, 7, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("es_wins",           0, 1, 1, 7, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 1));
        vecs.push_back(mk("no_we_unused",      0, 1, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("id_invalid",        0, 1, 0, 7, 7, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_r0",          0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("read_r0",           0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("issue_lw5b",        0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("flush_over_hold",   0, 1, 1, 0, 5, 0, 1, 0,12, 1, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0));
        vecs.push_back(mk("no_load_on_flush",  0, 1, 1,12, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));

        foreach (vecs[i]) run_vec(vecs[i]);

`ifdef HAZARD_PERF_EN
        pvecs.push_back(mk("p_reset",          1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        pvecs.push_back(mk("p_lw_a",           0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        pvecs.push_back(mk("p_hold_a",         0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        pvecs.push_back(mk("p_rel_a",          0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        pvecs.push_back(mk("p_lw_b",           0, 1, 0, 0, 0, 0, 0, 0, 5, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
        pvecs.push_back(mk("p_hold_b",         0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        pvecs.push_back(mk("p_rel_b",          0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2));
        foreach (pvecs[i]) run_vec(pvecs[i]);
        @(posedge clk);
        #1;
        check("perf", "perf_stall_cnt", perf_stall_cnt, 32'd2);
        check("perf", "perf_fwd_cnt", perf_fwd_cnt, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline. Sits beside id_stage and drives its stallD and ds_forward_ctrl inputs.
- Keeps a shadow scoreboard of the in-flight writers in ES, MS and WS, advanced by the stage handshakes.
- From the scoreboard it decides, per cycle, whether the ID operands are forwarded, stalled or read from the regfile.

Parameters:
- NSTAGE, 3, number of tracked post-ID stages (ES, MS, WS); fixed at 3 for this core.
- RW, 5, register address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ds_valid  in  1  ID holds a valid instruction
- ds_to_es_addr  in  10  {rs[9:5], rt[4:0]} of the ID instruction
- ds_rs_used  in  1  the ID instruction reads rs
- ds_rt_used  in  1  the ID instruction reads rt
- ifbranch  in  1  the ID instruction is beq/bne (resolved in ID)
- ds_dest  in  5  destination register of the ID instruction
- ds_gr_we  in  1  the ID instruction writes the regfile
- ds_is_load  in  1  the ID instruction is lw
- ds_to_es_fire  in  1  ds_to_es_valid & es_allowin
- es_to_ms_fire  in  1  ES handoff to MS
- ms_to_ws_fire  in  1  MS handoff to WS
- ws_retire  in  1  WS commits (regfile write cycle)
- ds_flush  in  1  drop the ID instruction (exception or redirect)
- stallD  out  2  00 normal, 01 hold ID (no allowin, bubble to ES), 10 flush ID (allowin, no valid to ES)
- ds_forward_ctrl  out  2  {rs_fwd, rt_fwd}; 1 = use ds_forward_bus
- fwd_rs_sel  out  2  forward source for rs: 00 regfile, 01 ES, 10 MS, 11 WS
- fwd_rt_sel  out  2  same encoding for rt

Behaviour:
- Scoreboard: entries SB_ES, SB_MS, SB_WS, each {v, dest, we, ld}.
- On ds_to_es_fire, SB_ES loads {1, ds_dest, ds_gr_we, ds_is_load}; otherwise on es_to_ms_fire SB_ES.v clears.
- es_to_ms_fire moves SB_ES into SB_MS; otherwise SB_MS.v clears on ms_to_ws_fire.
- ms_to_ws_fire moves SB_MS into SB_WS; otherwise SB_WS.v clears on ws_retire.
- All shifts within a cycle happen simultaneously, in register-transfer order.
- Reset clears every v and makes all outputs 0 in the following cycle. Reset mid-stream discards all in-flight entries; no stale forward may appear.
- Match for operand X in stage S: SB_S.v & SB_S.we & SB_S.dest==X & X!=0 & X_used & ds_valid.
- Priority is ES > MS > WS (youngest writer wins). fwd_*_sel encodes the winning stage, or 00 if no stage matches.
- ds_forward_ctrl bit = (sel != 00) & ~stall.
- Load-use stall: a match in ES with SB_ES.ld forces stallD=01.
- Branch stall:
  - ifbranch with any ES match forces stallD=01 (the ALU result is not forwarded into compare).
  - ifbranch with a match in MS where SB_MS.ld also forces stallD=01.
- While stalled, ds_forward_ctrl=00 and fwd sels read 00. The stall releases the cycle after the producer advances. Stall decisions are purely combinational on the current scoreboard and are never registered.
- ds_flush has priority over stall: stallD=10 that cycle and the scoreboard does not load.
- ds_valid=0: stallD=00, forwards 00.
- A simultaneous ws_retire and match in WS still forwards from WS, because the regfile write is not visible in the same cycle.

Optional Feature:
- HAZARD_PERF_EN defined adds outputs:
  - perf_stall_cnt[31:0]: counts cycles with stallD=01, wraps at 2^32.
  - perf_fwd_cnt[31:0]: counts cycles with any forward bit set.
  - Both counters are cleared by reset.
- Without the macro, neither the ports nor the counters exist and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - STALL_NONE=2'b00, STALL_HOLD=2'b01, STALL_FLUSH=2'b10
  - FWD_RF/ES/MS/WS select codes
  - sb_entry_t {v, dest[4:0], we, ld}, added to mycpu.h as macros and bus width
- One sub-module, hz_match: compares one operand against the three entries and returns {hit, sel, ld_hit_es, ld_hit_ms}. It is instantiated twice, for rs and rt.

Test Plan:
- addu $3 in ES, ID reads rs=$3 (used), not a branch -> fwd_rs_sel=01, ds_forward_ctrl=10, stallD=00.
- lw $5 in ES, ID addu reads rt=$5 -> stallD=01 for 1 cycle. Next cycle (lw in MS): stallD=00, fwd_rt_sel=10.
- beq reads $4 while addiu $4 is in ES -> stallD=01. After es_to_ms_fire: fwd_rs_sel=10, stallD=00.
- $7 written in both ES and WS, ID reads $7 -> fwd_*_sel=01 (ES wins). Dest $0 in ES with ID reading $0 -> sel 00.
- Load-use stall active and ds_flush=1 same cycle -> stallD=10 and SB_ES does not load. Reset asserted with 3 entries valid -> next cycle all sel 00, stallD=00.
- HAZARD_PERF_EN with the load-use scenario run twice -> perf_stall_cnt=2, perf_fwd_cnt=2.
